// File: rtl/vga_pkg.sv
// Shared definitions for the video / SRAM subsystem.
//   H_RES, V_RES    : active raster size; H_RES is also the SRAM row pitch in bytes
//   ADDR_W          : external SRAM address width (128K x 8)
//   phase_e         : names of the eight clockPhase steps of one access slot
//   pending_write_t : layout of the 25-bit MPU write-FIFO head {addr, data}
package vga_pkg;

  localparam int H_RES  = 320;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;

  typedef enum logic [2:0] {
    PH_RD1_ADDR  = 3'd0,
    PH_RD1_WAIT  = 3'd1,
    PH_RD1_DATA  = 3'd2,
    PH_RD2_WAIT  = 3'd3,
    PH_RD2_DATA  = 3'd4,
    PH_WR_SETUP  = 3'd5,
    PH_WR_STROBE = 3'd6,
    PH_WR_END    = 3'd7
  } phase_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } pending_write_t;

endpackage

// File: rtl/pixel_address_calc.sv
// Pixel-pair base address: y*H_RES + x_even, computed with shifts and adds.
//   i_x        : x of the pixel pair (bit 0 ignored for the address)
//   i_y        : y of the pixel pair
//   o_base     : 17-bit SRAM byte address of the even pixel
//   o_in_range : high when x < H_RES and y < V_RES
module pixel_address_calc
  import vga_pkg::*;
(
  input  logic [8:0]        i_x,
  input  logic [7:0]        i_y,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_in_range
);

  logic [ADDR_W-1:0] w_y_ext;
  logic [ADDR_W-1:0] w_x_even;

  assign w_y_ext  = {{(ADDR_W-8){1'b0}}, i_y};
  assign w_x_even = {{(ADDR_W-9){1'b0}}, i_x[8:1], 1'b0};

  // 320 = 256 + 64; even y=255, x=511 stays below 2^17.
  assign o_base     = (w_y_ext << 8) + (w_y_ext << 6) + w_x_even;
  assign o_in_range = (i_x < 9'(H_RES)) && (i_y < 8'(V_RES));

endmodule

// File: rtl/sram_access_scheduler.sv
// Time-slots the 128Kx8 external SRAM between the video pixel-pair fetch and the
// MPU pending-write FIFO. Each 8-phase slot: read pixel1, read pixel2, then at
// most one queued write. All outputs are registered.
// Optional feature macro: SRAM_BLANK_BURST_EN -- while displayActive is low at
// phase 0, phases 0..3 become an extra write window instead of the reads.
// Ports:
//   clock, reset (async, active-low), clockPhase (0..7 slot phase)
//   displayActive, readXCoord, readYCoord   : video request
//   pixel1, pixel2                           : fetched pair, stable for a slot
//   pendingWriteQueueReadBus/Empty/Request   : show-ahead write FIFO
//   address, dataIn, dataOut                 : SRAM bus
//   dataOutputEnable (tristate), outputEnable (OE#), writeEnable (WE#)
module sram_access_scheduler
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        clockPhase,
  input  logic              displayActive,
  input  logic [8:0]        readXCoord,
  input  logic [7:0]        readYCoord,
  output logic [7:0]        pixel1,
  output logic [7:0]        pixel2,
  input  logic [24:0]       pendingWriteQueueReadBus,
  input  logic              pendingWriteQueueReadEmpty,
  output logic              pendingWriteQueueReadRequest,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        dataIn,
  output logic [7:0]        dataOut,
  output logic              dataOutputEnable,
  output logic              outputEnable,
  output logic              writeEnable
);

  phase_e            w_phase;
  logic [ADDR_W-1:0] w_calc_base;
  logic              w_calc_in_range;
  pending_write_t    w_queue_head;
  logic              w_blank_now;   // this P0 starts a blanking write window
  logic              w_blank;       // current slot is a blanking slot

  logic [ADDR_W-1:0] r_address, w_address_next;
  logic [7:0]        r_data_out, w_data_out_next;
  logic              r_doe, w_doe_next;
  logic              r_oe_n, w_oe_n_next;
  logic              r_we_n, w_we_n_next;
  logic              r_req, w_req_next;
  logic [7:0]        r_pixel1, w_pixel1_next;
  logic [7:0]        r_pixel2, w_pixel2_next;
  logic [7:0]        r_pix1_stage, w_pix1_stage_next;
  logic [7:0]        r_pix2_stage, w_pix2_stage_next;
  logic [ADDR_W-1:0] r_base, w_base_next;
  logic              r_in_range, w_in_range_next;
  pending_write_t    r_wr, w_wr_next;
  logic              r_wr_pending, w_wr_pending_next;

  assign w_phase      = phase_e'(clockPhase);
  assign w_queue_head = pending_write_t'(pendingWriteQueueReadBus);

`ifdef SRAM_BLANK_BURST_EN
  logic r_blank;
  assign w_blank_now = !displayActive;
  assign w_blank     = r_blank;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_blank <= 1'b0;
    else if (w_phase == PH_RD1_ADDR) r_blank <= w_blank_now;
  end
`else
  logic w_unused_display;
  assign w_unused_display = displayActive;
  assign w_blank_now      = 1'b0;
  assign w_blank          = 1'b0;
`endif

  pixel_address_calc u_addr_calc (
    .i_x        (readXCoord),
    .i_y        (readYCoord),
    .o_base     (w_calc_base),
    .o_in_range (w_calc_in_range)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_address    <= '0;
      r_data_out   <= '0;
      r_doe        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_req        <= 1'b0;
      r_pixel1     <= '0;
      r_pixel2     <= '0;
      r_pix1_stage <= '0;
      r_pix2_stage <= '0;
      r_base       <= '0;
      r_in_range   <= 1'b0;
      r_wr         <= '0;
      r_wr_pending <= 1'b0;
    end else begin
      r_address    <= w_address_next;
      r_data_out   <= w_data_out_next;
      r_doe        <= w_doe_next;
      r_oe_n       <= w_oe_n_next;
      r_we_n       <= w_we_n_next;
      r_req        <= w_req_next;
      r_pixel1     <= w_pixel1_next;
      r_pixel2     <= w_pixel2_next;
      r_pix1_stage <= w_pix1_stage_next;
      r_pix2_stage <= w_pix2_stage_next;
      r_base       <= w_base_next;
      r_in_range   <= w_in_range_next;
      r_wr         <= w_wr_next;
      r_wr_pending <= w_wr_pending_next;
    end
  end

  // Next-state logic, one arm per slot phase
  always_comb begin
    w_address_next    = r_address;
    w_data_out_next   = r_data_out;
    w_doe_next        = r_doe;
    w_oe_n_next       = r_oe_n;
    w_we_n_next       = r_we_n;
    w_req_next        = 1'b0;
    w_pixel1_next     = r_pixel1;
    w_pixel2_next     = r_pixel2;
    w_pix1_stage_next = r_pix1_stage;
    w_pix2_stage_next = r_pix2_stage;
    w_base_next       = r_base;
    w_in_range_next   = r_in_range;
    w_wr_next         = r_wr;
    w_wr_pending_next = r_wr_pending;
    case (w_phase)
      PH_RD1_ADDR: begin
        // Previous slot's write has finished; release the bus before any read.
        w_doe_next = 1'b0;
        if (w_blank_now) begin
          w_oe_n_next       = 1'b1;
          w_wr_pending_next = !pendingWriteQueueReadEmpty;
          if (!pendingWriteQueueReadEmpty) begin
            w_req_next = 1'b1;
            w_wr_next  = w_queue_head;
          end
        end else begin
          w_base_next     = w_calc_base;
          w_in_range_next = w_calc_in_range;
          w_address_next  = w_calc_base;
          w_oe_n_next     = !w_calc_in_range;
        end
      end
      PH_RD1_WAIT: begin
        if (w_blank && r_wr_pending) begin
          w_address_next  = r_wr.addr;
          w_data_out_next = r_wr.data;
          w_doe_next      = 1'b1;
        end
      end
      PH_RD1_DATA: begin
        if (w_blank) begin
          if (r_wr_pending) w_we_n_next = 1'b0;
        end else begin
          w_pix1_stage_next = r_in_range ? dataIn : 8'h00;
          w_address_next    = r_base + 1'b1;
        end
      end
      PH_RD2_WAIT: begin
        w_we_n_next = 1'b1;
      end
      PH_RD2_DATA: begin
        if (!w_blank) w_pix2_stage_next = r_in_range ? dataIn : 8'h00;
        w_oe_n_next       = 1'b1;
        w_doe_next        = 1'b0;
        w_wr_pending_next = !pendingWriteQueueReadEmpty;
        if (!pendingWriteQueueReadEmpty) begin
          w_req_next = 1'b1;
          w_wr_next  = w_queue_head;
        end
      end
      PH_WR_SETUP: begin
        if (r_wr_pending) begin
          w_address_next  = r_wr.addr;
          w_data_out_next = r_wr.data;
          w_doe_next      = 1'b1;
        end
      end
      PH_WR_STROBE: begin
        if (r_wr_pending) w_we_n_next = 1'b0;
      end
      PH_WR_END: begin
        w_we_n_next = 1'b1;
        // Both pixels change together so the pair is coherent for a whole slot.
        if (!w_blank) begin
          w_pixel1_next = r_pix1_stage;
          w_pixel2_next = r_pix2_stage;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  assign pixel1                       = r_pixel1;
  assign pixel2                       = r_pixel2;
  assign address                      = r_address;
  assign dataOut                      = r_data_out;
  assign dataOutputEnable             = r_doe;
  assign outputEnable                 = r_oe_n;
  assign writeEnable                  = r_we_n;
  assign pendingWriteQueueReadRequest = r_req;

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Bench for sram_access_scheduler: SRAM and FIFO environment, a slot-level model
// (pixel bytes from address arithmetic and the write history, writes in FIFO
// order) and one negedge compare process, plus directed literal checks.
module tb_sram_access_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  clockPhase = 3'd0;
  logic        displayActive = 1'b1;
  logic [8:0]  readXCoord = '0;
  logic [7:0]  readYCoord = '0;
  logic [7:0]  pixel1, pixel2;
  logic [24:0] bus = '0;
  logic        empty = 1'b1;
  logic        req;
  logic [16:0] address;
  logic [7:0]  dataIn, dataOut;
  logic        dataOutputEnable, outputEnable, writeEnable;

  always #5 clock = ~clock;

  sram_access_scheduler dut (
    .clock                        (clock),
    .reset                        (reset),
    .clockPhase                   (clockPhase),
    .displayActive                (displayActive),
    .readXCoord                   (readXCoord),
    .readYCoord                   (readYCoord),
    .pixel1                       (pixel1),
    .pixel2                       (pixel2),
    .pendingWriteQueueReadBus     (bus),
    .pendingWriteQueueReadEmpty   (empty),
    .pendingWriteQueueReadRequest (req),
    .address                      (address),
    .dataIn                       (dataIn),
    .dataOut                      (dataOut),
    .dataOutputEnable             (dataOutputEnable),
    .outputEnable                 (outputEnable),
    .writeEnable                  (writeEnable)
  );

  // SRAM environment: unwritten bytes read as addr[7:0]; undriven bus reads 0xEE.
  logic [7:0] sram_mem     [0:131071];
  bit         sram_written [0:131071];
  always @(posedge clock) begin
    if (!writeEnable && dataOutputEnable) begin
      sram_mem[address]     <= dataOut;
      sram_written[address] <= 1'b1;
    end
  end
  assign dataIn = outputEnable ? 8'hEE
                : (sram_written[address] ? sram_mem[address] : address[7:0]);

  // Model state
  logic [24:0] fifo_q[$];
  logic [24:0] exp_wq[$];
  logic [7:0]  exp_wr[int];
  int   n_vec = 0, n_err = 0;
  bit   chk_en = 0, burst_build = 0;
  bit   req_seen = 0, we_low_seen = 0;
  bit   slot_blank = 0, slot_reads = 0;
  int   slot_base = 0, slot_pops = 0;
  logic [7:0] slot_p1 = 0, slot_p2 = 0, exp_pix1 = 0, exp_pix2 = 0;
  int   n_req = 0, n_we_low = 0, n_oe_low = 0, n_doe = 0;
  int   last_we_addr = -1, last_we_data = -1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int a);
    logic [31:0] av;
    av = a;
    return exp_wr.exists(a) ? exp_wr[a] : av[7:0];
  endfunction

  task automatic refresh_fifo();
    empty = (fifo_q.size() == 0);
    bus   = empty ? 25'd0 : fifo_q[0];
  endtask

  task automatic push(input int a, input int d);
    logic [16:0] a17;
    logic [7:0]  d8;
    a17 = a[16:0];
    d8  = d[7:0];
    fifo_q.push_back({a17, d8});
    refresh_fifo();
  endtask

  task automatic cycle();
    logic [2:0]  ph_edge;
    logic [24:0] e;
    @(posedge clock);
    ph_edge = clockPhase;
    #1;
    if (req_seen) begin
      e = fifo_q.pop_front();
      exp_wq.push_back(e);
      exp_wr[int'(e[24:8])] = e[7:0];
      slot_pops++;
    end
    if (we_low_seen && writeEnable && exp_wq.size() > 0) void'(exp_wq.pop_front());
    if (ph_edge == 3'd0) begin
      slot_blank = burst_build && !displayActive;
      slot_reads = !slot_blank && (readXCoord < 320) && (readYCoord < 240);
      if (!slot_blank) begin
        slot_base = int'(readYCoord) * 320 + (int'(readXCoord) / 2) * 2;
        slot_p1   = slot_reads ? model_byte(slot_base) : 8'h00;
        slot_p2   = slot_reads ? model_byte(slot_base + 1) : 8'h00;
      end
    end
    if (ph_edge == 3'd7 && !slot_blank) begin
      exp_pix1 = slot_p1;
      exp_pix2 = slot_p2;
    end
    req_seen    = req;
    we_low_seen = !writeEnable;
    if (req) n_req++;
    if (!outputEnable) n_oe_low++;
    if (dataOutputEnable) n_doe++;
    if (!writeEnable) begin
      n_we_low++;
      last_we_addr = int'(address);
      last_we_data = int'(dataOut);
    end
    clockPhase = ph_edge + 3'd1;
    refresh_fifo();
  endtask

  task automatic run_slot();
    slot_pops = 0;
    repeat (8) cycle();
  endtask

  // Per-cycle compare against the model and the bus rules
  always @(negedge clock) begin
    bit rd_win, doe_ok;
    if (chk_en) begin
      rd_win = slot_reads && (clockPhase inside {3'd1, 3'd2, 3'd3, 3'd4});
      check("oe_n", int'(outputEnable), int'(!rd_win));
      if (rd_win) check("rd_addr", int'(address), slot_base + ((clockPhase >= 3'd3) ? 1 : 0));
      check("pixel1", int'(pixel1), int'(exp_pix1));
      check("pixel2", int'(pixel2), int'(exp_pix2));
      if (!outputEnable) check("oe_doe_overlap", int'(dataOutputEnable), 0);
      if (dataOutputEnable) begin
        doe_ok = (clockPhase inside {3'd6, 3'd7, 3'd0}) ||
                 (slot_blank && (clockPhase inside {3'd2, 3'd3, 3'd4}));
        check("doe_window", int'(doe_ok), 1);
      end
      if (!writeEnable) begin
        check("we_phase", int'(clockPhase), (slot_blank && clockPhase < 3'd4) ? 3 : 7);
        check("we_doe", int'(dataOutputEnable), 1);
        check("we_entry_avail", int'(exp_wq.size() > 0), 1);
        if (exp_wq.size() > 0) begin
          check("we_addr", int'(address), int'(exp_wq[0][24:8]));
          check("we_data", int'(dataOut), int'(exp_wq[0][7:0]));
        end
      end
      if (req) begin
        check("req_nonempty", int'(empty), 0);
        check("req_phase", int'(clockPhase), (slot_blank && clockPhase < 3'd4) ? 1 : 5);
      end
    end
  end

  initial begin
    int s_req, s_we, s_doe, s_oe;
`ifdef SRAM_BLANK_BURST_EN
    burst_build = 1;
`endif
    refresh_fifo();
    #2 reset = 1'b0;
    #1;
    check("rst_pixel1", int'(pixel1), 0);
    check("rst_pixel2", int'(pixel2), 0);
    check("rst_address", int'(address), 0);
    check("rst_dataOut", int'(dataOut), 0);
    check("rst_doe", int'(dataOutputEnable), 0);
    check("rst_oe_n", int'(outputEnable), 1);
    check("rst_we_n", int'(writeEnable), 1);
    check("rst_req", int'(req), 0);
    repeat (3) @(posedge clock);
    #1;
    clockPhase = 3'd0;
    reset = 1'b1;
    chk_en = 1;

    // Basic pair fetch
    readXCoord = 9'd10; readYCoord = 8'd2;
    run_slot();
    check("model_base_10_2", slot_base, 650);
    check("pair_10_2_p1", int'(pixel1), 8'h8A);
    check("pair_10_2_p2", int'(pixel2), 8'h8B);

    // Single queued write
    push(17'h12C05, 8'h5A);
    s_req = n_req; s_we = n_we_low;
    run_slot();
    check("wr1_req_pulses", n_req - s_req, 1);
    check("wr1_we_cycles", n_we_low - s_we, 1);
    check("wr1_we_addr", last_we_addr, 17'h12C05);
    check("wr1_we_data", last_we_data, 8'h5A);

    // Empty FIFO: idle write windows
    s_req = n_req; s_we = n_we_low;
    run_slot();
    s_doe = n_doe;
    repeat (3) run_slot();
    check("idle_req", n_req - s_req, 0);
    check("idle_we", n_we_low - s_we, 0);
    check("idle_doe", n_doe - s_doe, 0);

    // Out-of-range and extreme in-range coordinates
    readXCoord = 9'd320; readYCoord = 8'd5;
    s_oe = n_oe_low;
    run_slot();
    check("oor_x_oe", n_oe_low - s_oe, 0);
    check("oor_x_p1", int'(pixel1), 0);
    check("oor_x_p2", int'(pixel2), 0);
    readXCoord = 9'd319; readYCoord = 8'd239;
    run_slot();
    check("max_p1", int'(pixel1), 8'hFE);
    check("max_p2", int'(pixel2), 8'hFF);
    readXCoord = 9'd0; readYCoord = 8'd240;
    s_oe = n_oe_low;
    run_slot();
    check("oor_y_oe", n_oe_low - s_oe, 0);
    check("oor_y_p1", int'(pixel1), 0);

    // Write to the pixel being read: read first, new value next slot
    readXCoord = 9'd11; readYCoord = 8'd2;
    push(650, 8'h77);
    run_slot();
    check("raw_old_p1", int'(pixel1), 8'h8A);
    run_slot();
    check("raw_new_p1", int'(pixel1), 8'h77);
    check("raw_new_p2", int'(pixel2), 8'h8B);

    // Blanking
    displayActive = 1'b0;
    readXCoord = 9'd100; readYCoord = 8'd1;
`ifdef SRAM_BLANK_BURST_EN
    push(17'h1E000, 8'hA0); push(17'h1E001, 8'hA1); push(17'h1E002, 8'hA2);
    run_slot();
    check("burst_slot1_pops", slot_pops, 2);
    run_slot();
    check("burst_slot2_pops", slot_pops, 1);
    check("burst_hold_p1", int'(pixel1), 8'h77);
    check("burst_hold_p2", int'(pixel2), 8'h8B);
`else
    push(17'h1E000, 8'hA0); push(17'h1E001, 8'hA1);
    run_slot();
    check("blank_slot1_pops", slot_pops, 1);
    check("blank_read_p1", int'(pixel1), 8'hA4);
    run_slot();
    check("blank_slot2_pops", slot_pops, 1);
    check("blank_read_p2", int'(pixel2), 8'hA5);
`endif
    displayActive = 1'b1;
    run_slot();

    // Reset in the middle of a write strobe
    push(17'h1F000, 8'h11); push(17'h1F001, 8'h22);
    repeat (7) cycle();
    check("pre_rst_we_low", int'(writeEnable), 0);
    #2 reset = 1'b0;
    chk_en = 0;
    #1;
    check("midrst_we_n", int'(writeEnable), 1);
    check("midrst_doe", int'(dataOutputEnable), 0);
    check("midrst_oe_n", int'(outputEnable), 1);
    exp_wq.delete();
    req_seen = 0; we_low_seen = 0; slot_reads = 0; slot_blank = 0;
    exp_pix1 = 0; exp_pix2 = 0;
    clockPhase = 3'd0;
    refresh_fifo();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk_en = 1;
    run_slot();
    run_slot();
    check("postrst_we_addr", last_we_addr, 17'h1F001);
    check("postrst_we_data", last_we_data, 8'h22);
    check("postrst_written_next", int'(sram_written[17'h1F001]), 1);
    check("postrst_dropped_entry", int'(sram_written[17'h1F000]), 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_access_scheduler.md
Name: sram_access_scheduler

Overview:
- Time-slots the single 128K×8 external SRAM between two requesters: the video pixel-pair fetch and the MPU pending-write queue.
- Each 8-phase slot (`clockPhase` 0..7 from the clock generator) does:
  - two reads, pixel1 then pixel2, for the coordinates the video output requests;
  - then at most one queued write.
- Sits between the video output, the MPU interface's write FIFO and the SRAM pins. It replaces ad-hoc sequencing in the top level.

Parameters:
- H_RES, 320, active pixels per line; also the row pitch in bytes.
- V_RES, 240, active lines.
- ADDR_W, 17, SRAM address width.

Ports:
- clock  in  1  system clock, one clock domain; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clockPhase  in  3  slot phase, increments by 1 per clock, wraps 7→0.
- displayActive  in  1  high during visible region.
- readXCoord  in  9  x of the pixel pair; bit 0 ignored.
- readYCoord  in  8  y of the pixel pair.
- pixel1  out  8  even pixel of the pair.
- pixel2  out  8  odd pixel of the pair.
- pendingWriteQueueReadBus  in  25  show-ahead FIFO head: [24:8] address, [7:0] data.
- pendingWriteQueueReadEmpty  in  1  FIFO empty.
- pendingWriteQueueReadRequest  out  1  one-cycle pop.
- address  out  17  SRAM address.
- dataIn  in  8  SRAM read data.
- dataOut  out  8  SRAM write data.
- dataOutputEnable  out  1  drives the tristate buffer at top level.
- outputEnable  out  1  SRAM OE#, active-low.
- writeEnable  out  1  SRAM WE#, active-low.

Behaviour:
- Reset (async assert) values:
  - pixel1 = pixel2 = 0; address = 0; dataOut = 0; dataOutputEnable = 0; outputEnable = 1; writeEnable = 1; pendingWriteQueueReadRequest = 0.
  - Reset asserted mid-write: WE#/DOE deassert immediately. The already-popped entry is discarded, with no retry.
- Pair address = y·H_RES + {x[8:1],1'b0}, i.e. (y<<8)+(y<<6)+x_even. Computed in 17 bits with no overflow; max is 76799.
- Coordinates are out of range when x ≥ H_RES or y ≥ V_RES. In that case:
  - the reads are suppressed (OE# stays high);
  - the pair latches 0.
- Phase sequence (registered outputs take effect in the cycle after the phase is sampled):
  - P0: latch coords; address ← pair base; OE# ← 0.
  - P1: hold.
  - P2: dataIn → pixel1Next; address ← base+1.
  - P3: hold.
  - P4: dataIn → pixel2Next; OE# ← 1. If !empty: pulse pendingWriteQueueReadRequest and capture bus into the write register; else mark slot idle.
  - P5: if write pending: address, dataOut ← entry; DOE ← 1.
  - P6: WE# ← 0.
  - P7: WE# ← 1, address and data held. pixel1/pixel2 ← pixel1Next/pixel2Next (both update together; stable for the whole next slot).
  - Next P0: DOE ← 0.
- Read latency: coordinates sampled at P0 appear on pixel1/pixel2 after P7, i.e. 8 clocks.
- Bus-turnaround rules:
  - OE#=0 and DOE=1 are never true in the same cycle.
  - WE#=0 only while DOE=1, with address stable one cycle before and after.
- At most one pop per slot. Request is never asserted while empty=1.
- An empty FIFO gives an idle write window: no SRAM activity at P5–P7.
- A write to the address currently being read is ordered read-first within the slot.

Optional Feature:
- Macro SRAM_BLANK_BURST_EN.
- Defined: while displayActive=0 at P0, phases P0–P3 form an extra write window:
  - P0 pop if !empty; P1 drive; P2 WE# low; P3 WE# high.
  - Reads are skipped and pixel1/pixel2 hold.
  - Gives up to 2 writes per slot in blanking.
- Undefined: reads run every slot regardless of displayActive; 1 write per slot max.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES, V_RES, ADDR_W;
  - enum of the eight phase names;
  - packed struct pending_write_t {addr[16:0], data[7:0]} matching the 25-bit bus.
- One sub-module, pixel_address_calc: pure shift-add of (x, y) → 17-bit base plus an in-range flag.

Test Plan:
- SRAM model preloaded with byte = addr[7:0]; x=10, y=2 → address 650 then 651; after P7, pixel1=0x8A, pixel2=0x8B.
- FIFO holds {0x12C05, 0x5A} → one request pulse at P4; WE# low exactly at P6 with address 0x12C05, data 0x5A; DOE never overlaps OE# low.
- FIFO empty for 4 slots → request never asserted; WE# and DOE stay inactive.
- x=320, y=5 → OE# stays high during reads; pixel1=pixel2=0.
- Reset pulled low at P6 of a write → WE#=1, DOE=0, OE#=1 in the same cycle; after release, the next write comes from the next FIFO entry.
- With SRAM_BLANK_BURST_EN, displayActive=0 and 3 entries queued → 2 pops in slot 1 (P0, P4), 1 in slot 2; pixels unchanged.
